controle_mult: RTL and testbench

Sequencer for the X/Y/Z register + ALU datapath. It runs one operation per start pulse: ADD, SUB, or shift-and-add MUL.
- It drives the register command codes tx/ty/tz, the ALU op tula and the ALU B-operand select.
- It reads back Y status bits and reports busy/done to the upstream block.
- It sits between the top-level instruction source and the datapath, alongside the existing fixed-sequence controller.

---
 rtl/controle_mult.sv | 127 ++++++++++++
 tb/tb_controle_mult.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/controle_mult.sv
// Sequencer for the X/Y/Z register + ALU datapath: one ADD, SUB or
// shift-and-add MUL per accepted start pulse.
module controle_mult #(
  parameter int unsigned NBITS = 8,
  parameter int unsigned CW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic          y_lsb,
  input  logic          y_zero,
  output logic [2:0]    tx,
  output logic [2:0]    ty,
  output logic [2:0]    tz,
  output logic [1:0]    tula,
  output logic          sel_b,
  output logic          busy,
  output logic          done,
  output logic [2:0]    estado,
  output logic [CW-1:0] contador
);

  localparam logic [2:0] CmdClear  = 3'd0;
  localparam logic [2:0] CmdLoad   = 3'd1;
  localparam logic [2:0] CmdHold   = 3'd2;
  localparam logic [2:0] CmdShiftl = 3'd3;
  localparam logic [2:0] CmdShiftr = 3'd4;

  localparam logic [CW-1:0] LastIter = CW'(NBITS - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoadA = 3'd1,
    StLoadB = 3'd2,
    StAlu   = 3'd3,
    StMtest = 3'd4,
    StMshift = 3'd5,
    StDone  = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    tx      = CmdHold;
    ty      = CmdHold;
    tz      = CmdHold;
    tula    = 2'd0;
    sel_b   = 1'b0;
    done    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (op == 2'd3) begin
            state_d = StDone;
          end else begin
            state_d = StLoadA;
            op_d    = op;
            cnt_d   = '0;
          end
        end
      end
      StLoadA: begin
        tx      = CmdLoad;
        tz      = CmdClear;
        state_d = StLoadB;
      end
      StLoadB: begin
        ty      = CmdLoad;
        state_d = (op_q == 2'd2) ? StMtest : StAlu;
      end
      StAlu: begin
        tula    = {1'b0, op_q[0]};
        sel_b   = 1'b0;
        tz      = CmdLoad;
        state_d = StDone;
      end
      StMtest: begin
        if (y_zero) begin
          // Remaining multiplier bits are all zero: nothing left to add.
          state_d = StDone;
        end else begin
          if (y_lsb) begin
            tula  = 2'd0;
            sel_b = 1'b1;
            tz    = CmdLoad;
          end
          state_d = StMshift;
        end
      end
      StMshift: begin
        tx      = CmdShiftl;
        ty      = CmdShiftr;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LastIter) ? StDone : StMtest;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign estado   = state_q;
  assign contador = cnt_q;

endmodule

// File: tb/tb_controle_mult.sv
// Self-checking bench for controle_mult with a behavioural X/Y/Z + ALU
// datapath and a scoreboard of expected per-operation results.
module tb_controle_mult;
  localparam int unsigned NBITS = 8;
  localparam int unsigned CW    = 4;

  logic          clock = 1'b0;
  logic          reset, start, y_lsb, y_zero;
  logic [1:0]    op;
  logic [2:0]    tx, ty, tz, estado;
  logic [1:0]    tula;
  logic          sel_b, busy, done;
  logic [CW-1:0] contador;

  always #5 clock = ~clock;

  controle_mult #(.NBITS(NBITS), .CW(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .y_lsb(y_lsb), .y_zero(y_zero), .tx(tx), .ty(ty), .tz(tz),
    .tula(tula), .sel_b(sel_b), .busy(busy), .done(done),
    .estado(estado), .contador(contador)
  );

  // Datapath model: X and Z are 16 bits wide so a full 8x8 product fits.
  logic [15:0] x_r, z_r, alu_b, alu_res, a_val;
  logic [7:0]  y_r, b_val;

  always_comb begin
    alu_b   = sel_b ? z_r : {8'h00, y_r};
    alu_res = tula[0] ? (x_r - alu_b) : (x_r + alu_b);
  end
  assign y_lsb  = y_r[0];
  assign y_zero = (y_r == 8'h00);

  always @(posedge clock) begin
    case (tx)
      3'd0: x_r <= '0;
      3'd1: x_r <= a_val;
      3'd3: x_r <= x_r << 1;
      3'd4: x_r <= x_r >> 1;
      default: ;
    endcase
    case (ty)
      3'd0: y_r <= '0;
      3'd1: y_r <= b_val;
      3'd3: y_r <= y_r << 1;
      3'd4: y_r <= y_r >> 1;
      default: ;
    endcase
    case (tz)
      3'd0: z_r <= '0;
      3'd1: z_r <= alu_res;
      default: ;
    endcase
  end

  typedef struct {
    int            lat;
    logic [15:0]   z;
    logic [15:0]   zwidth;
    logic [CW-1:0] cnt;
    logic [31:0]   zmask;
    int            loads;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one start pulse, then observes the operation until done.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                        input logic [7:0] b, input int lat, input logic [15:0] z,
                        input logic [15:0] zw, input logic [CW-1:0] cnt,
                        input logic [31:0] zmask);
    exp_t e;
    int   lat_obs = -1;
    int   loads   = 0;
    bit   busy_ok = 1'b1;
    logic [31:0] mask = '0;
    e.lat = lat; e.z = z; e.zwidth = zw; e.cnt = cnt; e.zmask = zmask;
    e.loads = (o == 2'd3) ? 0 : 2;
    sb.push_back(e);

    @(negedge clock);
    a_val = a; b_val = b; op = o; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int c = 1; c <= 40 && lat_obs < 0; c++) begin
      @(negedge clock);
      if (!busy) busy_ok = 1'b0;
      if (tz == 3'd1) mask[c] = 1'b1;
      if (tx == 3'd1) loads++;
      if (ty == 3'd1) loads++;
      if (done) lat_obs = c;
    end

    e = sb.pop_front();
    check({tag, " latency"}, 32'(lat_obs), 32'(e.lat));
    check({tag, " z"}, {16'h0, z_r & e.zwidth}, {16'h0, e.z});
    check({tag, " contador"}, {28'h0, contador}, {28'h0, e.cnt});
    check({tag, " zload cycles"}, mask, e.zmask);
    check({tag, " x/y loads"}, 32'(loads), 32'(e.loads));
    check({tag, " busy while active"}, {31'h0, busy_ok}, 32'd1);
    @(negedge clock);
    check({tag, " busy after done"}, {31'h0, busy}, 32'd0);
  endtask

  logic [31:0] full_mask;
  int          n_la;
  bit          found;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'd0; a_val = '0; b_val = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset estado", {29'h0, estado}, 32'd0);
    check("reset busy/done", {30'h0, busy, done}, 32'd0);
    check("reset contador", {28'h0, contador}, 32'd0);
    check("reset commands", {23'h0, tx, ty, tz}, {23'h0, 3'd2, 3'd2, 3'd2});
    check("reset alu ctl", {29'h0, tula, sel_b}, 32'd0);
    reset = 1'b0;

    run_op("add", 2'd0, 16'd5, 8'd3, 4, 16'd8, 16'hFFFF, '0, 32'h8);
    run_op("sub", 2'd1, 16'd5, 8'd7, 4, 16'h00FE, 16'h00FF, '0, 32'h8);
    run_op("mul6x5", 2'd2, 16'd6, 8'd5, 10, 16'd30, 16'hFFFF, 4'd3, 32'h88);
    repeat (3) @(negedge clock);
    check("contador held in idle", {28'h0, contador}, 32'd3);

    full_mask = '0;
    for (int i = 0; i < 8; i++) full_mask[3 + 2 * i] = 1'b1;
    run_op("mul255x255", 2'd2, 16'd255, 8'd255, 19, 16'd65025, 16'hFFFF, 4'd8, full_mask);
    run_op("mul b=0", 2'd2, 16'd9, 8'd0, 4, 16'd0, 16'hFFFF, 4'd0, 32'h0);
    run_op("nop", 2'd3, 16'd1, 8'd1, 1, 16'd0, 16'hFFFF, 4'd0, 32'h0);

    // start held high: the second operation must only begin from IDLE.
    @(negedge clock);
    a_val = 16'd6; b_val = 8'd5; op = 2'd2; start = 1'b1;
    @(posedge clock);
    n_la = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (estado == 3'd1) n_la++;
      if (c == 10) check("held start done@10", {31'h0, done}, 32'd1);
    end
    check("held start single LOADA", 32'(n_la), 32'd1);
    @(negedge clock);
    check("held start idle@11", {28'h0, busy, estado}, 32'd0);
    @(negedge clock);
    check("held start reload@12", {29'h0, estado}, 32'd1);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clock);
      if (done) found = 1'b1;
    end
    check("held start second done", {31'h0, found}, 32'd1);
    check("held start second z", {16'h0, z_r}, 32'd30);

    // Reset mid-MUL, during the second MSHIFT.
    @(negedge clock);
    a_val = 16'd255; b_val = 8'd255; op = 2'd2; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clock);
      if (estado == 3'd5 && contador == 4'd1) found = 1'b1;
    end
    check("reach MSHIFT", {31'h0, found}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("mid reset estado", {29'h0, estado}, 32'd0);
    check("mid reset busy/done", {30'h0, busy, done}, 32'd0);
    check("mid reset contador", {28'h0, contador}, 32'd0);
    check("mid reset commands", {23'h0, tx, ty, tz}, {23'h0, 3'd2, 3'd2, 3'd2});
    reset = 1'b0;

    run_op("add after reset", 2'd0, 16'd100, 8'd27, 4, 16'd127, 16'hFFFF, '0, 32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
